dds_freq_ctrl: RTL
==================

// Module: dds_freq_ctrl
// PURPOSE
//  - Consumes the single-cycle debounced pulses (IntBTN style) from the button debouncers: UP, DOWN, STEP.
//  - Maintains the user output frequency (Hz) and a selectable decade step size.
//  - Converts the frequency to a DDS tuning word with a sequential shift-add multiplier.
//  - Offers each new word to the phase accumulator over a valid/ready handshake.
// PARAMETERS
//  FREQ_W      24          frequency register width (Hz)
//  TW_W        32          tuning word width
//  FREQ_MIN    1           lowest allowed frequency, Hz
//  FREQ_MAX    10_000_000  highest allowed frequency, Hz
//  FREQ_INIT   1000        frequency after reset, Hz
//  TW_SCALE    15271       round(2^(TW_W+SCALE_SHIFT)/72e6), 16-bit constant
//  SCALE_SHIFT 8           right shift applied to FREQ*TW_SCALE
// PORTS
//  Fg_CLK    in   1       system clock (72 MHz)
//  RESET     in   1       synchronous reset, active-high
//  BTN_UP    in   1       1-cycle pulse: FREQ += step
//  BTN_DN    in   1       1-cycle pulse: FREQ -= step
//  BTN_STEP  in   1       1-cycle pulse: advance step index
//  FREQ_HZ   out  FREQ_W  current frequency setting
//  STEP_IDX  out  3       step index 0..6 -> 1,10,100,1k,10k,100k,1M Hz
//  TW        out  TW_W    tuning word; stable while TW_VALID=1
//  TW_VALID  out  1       TW offered to accumulator
//  TW_READY  in   1       accumulator accepts TW
//  BUSY      out  1       FSM not in IDLE
// BEHAVIOUR
//  - Reset: FREQ_HZ=FREQ_INIT, STEP_IDX=0, TW=0, TW_VALID=0, BUSY=0, FSM=IDLE, dirty=1.
//    A recalculation is forced after reset.
//  - Edits apply in any FSM state.
//    FREQ_HZ updates on the edge after the sampling edge; dirty is set on the same edge.
//  - BTN_UP and BTN_DN high together: no change, dirty not set.
//  - BTN_STEP: STEP_IDX 6 wraps to 0. Does not set dirty. May coincide with UP/DN.
//    When coincident, UP/DN uses the old step.
//  - Arithmetic uses FREQ_W+1 bits, so there is no silent overflow.
//    If FREQ+step > FREQ_MAX, the result is clamped; if FREQ-step < FREQ_MIN, likewise.
//  - Clamping rule depends on WRAP_EN (see CONFIGURATION).
//  - FSM IDLE -> CALC: when dirty=1. Snapshots FREQ_HZ into the multiplicand, clears dirty, clears the accumulator.
//  - FSM CALC: exactly FREQ_W cycles.
//    Each cycle, LSB-first shift-add of TW_SCALE into a FREQ_W+16-bit accumulator.
//  - FSM CALC -> OFFER: TW = acc >> SCALE_SHIFT (truncated, low TW_W bits). TW_VALID=1.
//  - FSM OFFER: TW and TW_VALID held until the edge where TW_VALID & TW_READY.
//    Next cycle TW_VALID=0 and FSM=IDLE.
//    A dirty flag set during CALC/OFFER triggers a fresh CALC from IDLE.
//    Stale words are still delivered; only the latest pending edit is recalculated.
//  - Latency: pulse sampled at edge 0 -> TW_VALID=1 after edge FREQ_W+2, provided FSM was IDLE.
//  - TW_READY high during IDLE/CALC is ignored.
//  - RESET mid-CALC/OFFER: returns to reset values next edge. The in-flight word is discarded.
// CONFIGURATION
//  - Macro FREQ_WRAP_EN, when defined: overflow above FREQ_MAX loads FREQ_MIN; underflow below FREQ_MIN loads FREQ_MAX.
//  - Macro FREQ_WRAP_EN, when not defined (default): overflow saturates at FREQ_MAX; underflow saturates at FREQ_MIN.
// TESTING
//  1. Reset, TW_READY=1 -> TW_VALID after FREQ_W+2 cycles, TW=59652 (1000 Hz); one transfer only.
//  2. STEP x6 (idx 6 = 1 MHz), UP from 1000 -> FREQ_HZ=1_001_000.
//     Then TW=1_001_000*15271>>8=59_711_996.
//  3. TW_READY=0 in OFFER for 50 cycles -> TW/TW_VALID stable.
//     UP pulse there -> after handshake, a second CALC starts and delivers the new word.
//  4. FREQ=9_999_995, step 10, UP -> 10_000_000 (saturate).
//     FREQ=5, step 10, DN -> 1. With FREQ_WRAP_EN: 1 and 10_000_000 respectively.
//  5. BTN_UP+BTN_DN same cycle -> FREQ_HZ unchanged, no CALC.
//     BTN_STEP at idx 6 -> idx 0.
//  6. RESET asserted mid-CALC -> next edge FREQ_HZ=1000, TW_VALID=0, BUSY=0; recalc follows.

Source files
------------

// File: rtl/dds_freq_ctrl.sv
// DDS frequency controller: button edits with clamping, shift-add tuning word multiply, valid/ready offer.
// Build option: define FREQ_WRAP_EN to wrap out-of-range edits to the opposite limit instead of saturating.
module dds_freq_ctrl #(
    parameter int FREQ_W      = 24,
    parameter int TW_W        = 32,
    parameter int FREQ_MIN    = 1,
    parameter int FREQ_MAX    = 10_000_000,
    parameter int FREQ_INIT   = 1000,
    parameter int TW_SCALE    = 15271,
    parameter int SCALE_SHIFT = 8
) (
    input  logic              Fg_CLK,
    input  logic              RESET,
    input  logic              BTN_UP,
    input  logic              BTN_DN,
    input  logic              BTN_STEP,
    output logic [FREQ_W-1:0] FREQ_HZ,
    output logic [2:0]        STEP_IDX,
    output logic [TW_W-1:0]   TW,
    output logic              TW_VALID,
    input  logic              TW_READY,
    output logic              BUSY
);

    localparam int ACC_W = FREQ_W + 16;
    localparam int CNT_W = $clog2(FREQ_W);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(FREQ_W - 1);
    localparam logic [FREQ_W:0]   MAX_X    = (FREQ_W+1)'(FREQ_MAX);
    localparam logic [FREQ_W:0]   MIN_X    = (FREQ_W+1)'(FREQ_MIN);
`ifdef FREQ_WRAP_EN
    localparam logic [FREQ_W-1:0] OVF_LOAD = FREQ_W'(FREQ_MIN);
    localparam logic [FREQ_W-1:0] UNF_LOAD = FREQ_W'(FREQ_MAX);
`else
    localparam logic [FREQ_W-1:0] OVF_LOAD = FREQ_W'(FREQ_MAX);
    localparam logic [FREQ_W-1:0] UNF_LOAD = FREQ_W'(FREQ_MIN);
`endif

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_OFFER} state_t;

    state_t            state_q, state_d;
    logic              up_q, dn_q, stp_q;
    logic [FREQ_W-1:0] freq_q, freq_d;
    logic [2:0]        idx_q, idx_d;
    logic              dirty_q;
    logic              edit;
    logic [FREQ_W-1:0] mult_q;
    logic [ACC_W-1:0]  addend_q;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  acc_scaled;
    logic [CNT_W-1:0]  cnt_q;
    logic [TW_W-1:0]   tw_q;
    logic [FREQ_W:0]   step_val, freq_ext, sum, diff;

    // Decade step table, widened by one bit so the sum/difference cannot overflow silently.
    always_comb begin
        step_val = (FREQ_W+1)'(1);
        case (idx_q)
            3'd0:    step_val = (FREQ_W+1)'(1);
            3'd1:    step_val = (FREQ_W+1)'(10);
            3'd2:    step_val = (FREQ_W+1)'(100);
            3'd3:    step_val = (FREQ_W+1)'(1_000);
            3'd4:    step_val = (FREQ_W+1)'(10_000);
            3'd5:    step_val = (FREQ_W+1)'(100_000);
            3'd6:    step_val = (FREQ_W+1)'(1_000_000);
            default: step_val = (FREQ_W+1)'(1);
        endcase
    end

    always_comb begin
        freq_ext = {1'b0, freq_q};
        sum      = freq_ext + step_val;
        diff     = freq_ext - step_val;
        edit     = up_q ^ dn_q;
        freq_d   = freq_q;
        if (up_q && !dn_q) begin
            freq_d = (sum > MAX_X) ? OVF_LOAD : sum[FREQ_W-1:0];
        end else if (dn_q && !up_q) begin
            // A borrow out of the top bit means the difference went negative.
            freq_d = (diff[FREQ_W] || (diff < MIN_X)) ? UNF_LOAD : diff[FREQ_W-1:0];
        end
        idx_d = idx_q;
        if (stp_q) begin
            idx_d = (idx_q == 3'd6) ? 3'd0 : idx_q + 3'd1;
        end
    end

    always_ff @(posedge Fg_CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (dirty_q) state_d = S_CALC;
            S_CALC:  if (cnt_q == LAST_CNT) state_d = S_OFFER;
            S_OFFER: if (TW_READY) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        BUSY     = (state_q != S_IDLE);
        TW_VALID = (state_q == S_OFFER);
    end

    always_comb begin
        acc_d      = acc_q + (mult_q[0] ? addend_q : '0);
        acc_scaled = acc_d >> SCALE_SHIFT;
    end

    always_ff @(posedge Fg_CLK) begin
        if (RESET) begin
            up_q     <= 1'b0;
            dn_q     <= 1'b0;
            stp_q    <= 1'b0;
            freq_q   <= FREQ_W'(FREQ_INIT);
            idx_q    <= 3'd0;
            dirty_q  <= 1'b1;
            mult_q   <= '0;
            addend_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            tw_q     <= '0;
        end else begin
            up_q   <= BTN_UP;
            dn_q   <= BTN_DN;
            stp_q  <= BTN_STEP;
            freq_q <= freq_d;
            idx_q  <= idx_d;
            // A fresh edit wins over the clear so an edit landing on the snapshot edge is not lost.
            if (edit) begin
                dirty_q <= 1'b1;
            end else if (state_q == S_IDLE && dirty_q) begin
                dirty_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (dirty_q) begin
                        mult_q   <= freq_q;
                        addend_q <= ACC_W'(TW_SCALE);
                        acc_q    <= '0;
                        cnt_q    <= '0;
                    end
                end
                S_CALC: begin
                    acc_q    <= acc_d;
                    mult_q   <= mult_q >> 1;
                    addend_q <= addend_q << 1;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        tw_q <= acc_scaled[TW_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign FREQ_HZ  = freq_q;
    assign STEP_IDX = idx_q;
    assign TW       = tw_q;

endmodule
